// File: rtl/ip_codma_bus_arbiter.sv
// Round-robin owner arbiter for the shared CODMA memory bus (read vs write engine).
// Each tenure is bounded by a hold watchdog; abort revokes ownership.
module ip_codma_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rd_req_i,
  input  logic       rd_done_i,
  output logic       rd_grant_o,
  input  logic       wr_req_i,
  input  logic       wr_done_i,
  output logic       wr_grant_o,
  input  logic       abort_i,
  output logic       bus_sel_o,
  output logic [1:0] owner_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2,
    ARB_GAP  = 2'd3
  } arb_state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  arb_state_t       state;
  logic             last_wr;
  logic [CNT_W-1:0] hold_cnt;
  logic             own_done;

  // Release pulse of whichever engine currently owns the bus.
  always_comb begin
    own_done = 1'b0;
    if (state == ARB_RD) own_done = rd_done_i;
    if (state == ARB_WR) own_done = wr_done_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      last_wr    <= 1'b1;
      hold_cnt   <= '0;
      rd_grant_o <= 1'b0;
      wr_grant_o <= 1'b0;
      bus_sel_o  <= 1'b0;
      owner_o    <= 2'b00;
      timeout_o  <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (!abort_i) begin
            // Tie goes to the engine that did not own the bus last.
            if (rd_req_i && (!wr_req_i || last_wr)) begin
              state      <= ARB_RD;
              hold_cnt   <= '0;
              rd_grant_o <= 1'b1;
              bus_sel_o  <= 1'b0;
              owner_o    <= 2'b01;
            end else if (wr_req_i) begin
              state      <= ARB_WR;
              hold_cnt   <= '0;
              wr_grant_o <= 1'b1;
              bus_sel_o  <= 1'b1;
              owner_o    <= 2'b10;
            end
          end
        end
        ARB_RD, ARB_WR: begin
          if (abort_i || own_done || (hold_cnt == HOLD_LAST)) begin
            state      <= ARB_GAP;
            last_wr    <= (state == ARB_WR);
            rd_grant_o <= 1'b0;
            wr_grant_o <= 1'b0;
            owner_o    <= 2'b00;
            timeout_o  <= !abort_i && !own_done;
          end else if (hold_cnt != CNT_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ARB_GAP: begin
          if (!abort_i) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
